// File: rtl/cla_multiword_seq_pkg.sv
// Shared constants for the multi-word CLA sequencer: datapath word width and FSM state codes.
package cla_multiword_seq_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cla_multiword_seq_cla_32bit.sv
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
// It exports the block-level propagate/generate so the caller can form carry-out from its own carry-in.
module cla_32bit
    import cla_multiword_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] s,
    output logic              gp,
    output logic              gg
);

    localparam int NGRP = WORD_W / 4;

    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] c;
    logic [NGRP-1:0]   grp_p;
    logic [NGRP-1:0]   grp_g;
    logic [NGRP:0]     grp_c;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        grp_p = '0;
        grp_g = '0;
        for (int k = 0; k < NGRP; k++) begin
            grp_p[k] = &p[4*k +: 4];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Second-level lookahead across groups; bit carries are then expanded inside each group.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = cin;
        c        = '0;
        for (int k = 0; k < NGRP; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
            c[4*k]     = grp_c[k];
            c[4*k+1]   = g[4*k] | (p[4*k] & grp_c[k]);
            c[4*k+2]   = g[4*k+1] | (p[4*k+1] & g[4*k])
                       | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3]   = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                       | (p[4*k+2] & p[4*k+1] & g[4*k])
                       | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
    end

    always_comb begin
        gp = 1'b1;
        gg = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            gg = grp_g[k] | (grp_p[k] & gg);
            gp = gp & grp_p[k];
        end
    end

    assign s = p ^ c;

endmodule

// File: rtl/cla_multiword_seq.sv
// NWORDS*32-bit add/subtract sequencer: one shared 32-bit CLA, one word per cycle, LSW first.
// Optional CLA_SEQ_ACCUM_EN adds acc_sel, which substitutes the current sum register for op_a.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | in_ready high, waiting for an operand handshake
//   RUN     | one word of the result written per cycle, idx = word
//   DONE    | result held with out_valid high until out_ready
module cla_multiword_seq
    import cla_multiword_seq_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [32*NWORDS-1:0]   op_a,
    input  logic [32*NWORDS-1:0]   op_b,
    input  logic                   sub,
`ifdef CLA_SEQ_ACCUM_EN
    input  logic                   acc_sel,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [32*NWORDS-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W    = WORD_W * NWORDS;
    localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [1:0]        state;
    logic [IDXW-1:0]   idx;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic              sub_reg;
    logic              carry;

    logic [31:0]       base;
    logic [WORD_W-1:0] a_word;
    logic [WORD_W-1:0] b_word;
    logic [WORD_W-1:0] s_word;
    logic              gp;
    logic              gg;
    logic              carry_nxt;
    logic              last;
    logic [W-1:0]      a_sel;

    assign base      = 32'(idx) * 32'(WORD_W);
    assign a_word    = a_reg[base +: WORD_W];
    assign b_word    = b_reg[base +: WORD_W] ^ {WORD_W{sub_reg}};
    assign carry_nxt = gg | (gp & carry);
    assign last      = (idx == IDXW'(NWORDS - 1));

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

`ifdef CLA_SEQ_ACCUM_EN
    assign a_sel = acc_sel ? sum : op_a;
`else
    assign a_sel = op_a;
`endif

    cla_32bit u_cla (
        .a   (a_word),
        .b   (b_word),
        .cin (carry),
        .s   (s_word),
        .gp  (gp),
        .gg  (gg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
            carry   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a_sel;
                        b_reg   <= op_b;
                        sub_reg <= sub;
                        carry   <= sub;
                        idx     <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[base +: WORD_W] <= s_word;
                    carry               <= carry_nxt;
                    if (last) begin
                        cout  <= carry_nxt;
                        // Signed overflow: same-sign addends producing a result of the other sign.
                        ovf   <= (a_word[WORD_W-1] == b_word[WORD_W-1])
                              && (s_word[WORD_W-1] != a_word[WORD_W-1]);
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Randomized and directed bench for cla_multiword_seq against a wide-integer arithmetic model.
module tb_cla_multiword_seq;

    localparam int NW = 4;
    localparam int W  = 32 * NW;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
`ifdef CLA_SEQ_ACCUM_EN
    logic         acc_sel;
`endif

    int vectors;
    int miscompares;

    cla_multiword_seq #(.NWORDS(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
`ifdef CLA_SEQ_ACCUM_EN
        .acc_sel   (acc_sel),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain (W+1)-bit two's complement arithmetic.
    function automatic logic [W:0] ref_full(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] bp;
        bp = s ? ~b : b;
        return {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, s};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] bp;
        logic [W:0]   f;
        bp = s ? ~b : b;
        f  = ref_full(a, b, s);
        return (a[W-1] == bp[W-1]) && (f[W-1] != a[W-1]);
    endfunction

    function automatic logic [W-1:0] rand_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] rs, output logic rc, output logic ro, output int lat);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = sum; rc = cout; ro = ovf;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] rs; logic rc, ro; int lat;
        run_op(128'd5, 128'd3, 1'b0, rs, rc, ro, lat);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, cout, ovf} !== 4'b1000 || sum !== '0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, want 1 0 0 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic         ts [5];
        logic [W-1:0] rs; logic rc, ro; int lat;
        logic [W:0]   f;
        ta[0] = '1;                 tb[0] = 128'd1; ts[0] = 1'b0;
        ta[1] = '0;                 tb[1] = 128'd1; ts[1] = 1'b1;
        ta[2] = 128'd5;             tb[2] = 128'd3; ts[2] = 1'b1;
        ta[3] = {1'b0, {(W-1){1'b1}}}; tb[3] = 128'd1; ts[3] = 1'b0;
        ta[4] = {1'b1, {(W-1){1'b0}}}; tb[4] = 128'd1; ts[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], ts[i], rs, rc, ro, lat);
            f = ref_full(ta[i], tb[i], ts[i]);
            vectors++;
            if (rs !== f[W-1:0] || rc !== f[W] || ro !== ref_ovf(ta[i], tb[i], ts[i]) || lat != NW) begin
                miscompares++;
                $display("FAIL directed[%0d]: sum=%h cout=%b ovf=%b lat=%0d, want sum=%h cout=%b ovf=%b lat=%0d",
                         i, rs, rc, ro, lat, f[W-1:0], f[W], ref_ovf(ta[i], tb[i], ts[i]), NW);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, rs; logic s, rc, ro; int lat;
        logic [W:0]   f;
        for (int i = 0; i < 40; i++) begin
            a = rand_w(); b = rand_w(); s = 1'($urandom_range(1));
            if (i % 5 == 0) b = ~a;
            if (i % 7 == 0) a = {$urandom_range(1) ? 1'b1 : 1'b0, {(W-1){1'b1}}};
            run_op(a, b, s, rs, rc, ro, lat);
            f = ref_full(a, b, s);
            vectors++;
            if (rs !== f[W-1:0] || rc !== f[W] || ro !== ref_ovf(a, b, s) || lat != NW) begin
                miscompares++;
                $display("FAIL random[%0d]: sum=%h cout=%b ovf=%b lat=%0d, want sum=%h cout=%b ovf=%b lat=%0d",
                         i, rs, rc, ro, lat, f[W-1:0], f[W], ref_ovf(a, b, s), NW);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a1, b1, a2, b2;
        logic [W:0]   f1, f2;
        int lat;
        a1 = rand_w(); b1 = rand_w(); a2 = rand_w(); b2 = rand_w();
        f1 = ref_full(a1, b1, 1'b0);
        f2 = ref_full(a2, b2, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        op_a = a1; op_b = b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        op_a = a2; op_b = b2; sub = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== f1[W-1:0] || cout !== f1[W]
                || ovf !== ref_ovf(a1, b1, 1'b0)) begin
                miscompares++;
                $display("FAIL backpressure hold[%0d]: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b, want 1 0 %h %b %b",
                         c, out_valid, in_ready, sum, cout, ovf, f1[W-1:0], f1[W], ref_ovf(a1, b1, 1'b0));
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (sum !== f2[W-1:0] || cout !== f2[W] || ovf !== ref_ovf(a2, b2, 1'b1) || lat != NW) begin
            miscompares++;
            $display("FAIL backpressure second op: sum=%h cout=%b ovf=%b lat=%0d, want %h %b %b lat=%0d",
                     sum, cout, ovf, lat, f2[W-1:0], f2[W], ref_ovf(a2, b2, 1'b1), NW);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] rs; logic rc, ro; int lat;
        @(negedge clk);
        op_a = '1; op_b = '1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, cout, ovf} !== 4'b1000 || sum !== '0) begin
            miscompares++;
            $display("FAIL reset mid-run: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, want 1 0 0 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(negedge clk); rst_n = 1'b1;
        run_op(128'd10, 128'd20, 1'b0, rs, rc, ro, lat);
        vectors++;
        if (rs !== 128'd30 || rc !== 1'b0 || ro !== 1'b0 || lat != NW) begin
            miscompares++;
            $display("FAIL after reset op: sum=%h cout=%b ovf=%b lat=%0d, want 30 0 0 lat=%0d",
                     rs, rc, ro, lat, NW);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
        op_a = '0; op_b = '0;
`ifdef CLA_SEQ_ACCUM_EN
        acc_sel = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
